secure_data_reader: RTL

SECURE_DATA_READER -- requirements
Module: secure_data_reader

---
 rtl/secure_data_reader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/secure_data_reader.sv
// Key-protected byte reader: write-once key, authenticated unlock, one-byte handshake transfers.
// Optional SDR_LOCKOUT_EN adds a timed lockout after MAX_FAILS consecutive failed attempts.
module secure_data_reader #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  input  logic [7:0] key_in,
  input  logic       auth_valid,
  input  logic [7:0] auth_key,
  input  logic       relock,
  input  logic [7:0] src_data,
  input  logic       src_ready,
  output logic       src_ack,
  input  logic       rd_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       auth_ok,
  output logic       auth_fail,
  output logic       unlocked,
  output logic       locked_out
);

  if (MAX_FAILS < 1 || MAX_FAILS > 255) begin : g_bad_max_fails
    $error("MAX_FAILS out of range");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : g_bad_lockout
    $error("LOCKOUT_CYCLES out of range");
  end

  typedef enum logic [2:0] {NOKEY, LOCKED, UNLOCKED, SEND, LOCKOUT} state_e;

  state_e     state_q;
  logic [7:0] key_q;
  logic [7:0] fail_cnt_q, fail_cnt_d;
  logic       relock_seen_q;
  logic [7:0] out_data_q;
  logic       out_valid_q, src_ack_q, auth_ok_q, auth_fail_q;

`ifdef SDR_LOCKOUT_EN
  localparam logic [7:0]  MAX_FAILS_B = 8'(MAX_FAILS);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCKOUT_CYCLES - 1);
  logic [15:0] lock_cnt_q;
`endif

  // saturating failure count
  always_comb fail_cnt_d = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= NOKEY;
      key_q         <= '0;
      fail_cnt_q    <= '0;
      relock_seen_q <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      src_ack_q     <= 1'b0;
      auth_ok_q     <= 1'b0;
      auth_fail_q   <= 1'b0;
`ifdef SDR_LOCKOUT_EN
      lock_cnt_q    <= '0;
`endif
    end else begin
      auth_ok_q   <= 1'b0;
      auth_fail_q <= 1'b0;
      src_ack_q   <= 1'b0;
      case (state_q)
        NOKEY: if (key_load) begin
          key_q   <= key_in;
          state_q <= LOCKED;
        end
        LOCKED: if (auth_valid) begin
          if (auth_key == key_q) begin
            auth_ok_q  <= 1'b1;
            fail_cnt_q <= '0;
            state_q    <= UNLOCKED;
          end else begin
            auth_fail_q <= 1'b1;
            fail_cnt_q  <= fail_cnt_d;
`ifdef SDR_LOCKOUT_EN
            if (fail_cnt_d >= MAX_FAILS_B) begin
              lock_cnt_q <= '0;
              state_q    <= LOCKOUT;
            end
`endif
          end
        end
        UNLOCKED: begin
          // relock wins over a simultaneous read request
          if (relock) state_q <= LOCKED;
          else if (rd_req && src_ready) begin
            out_data_q    <= src_data;
            out_valid_q   <= 1'b1;
            relock_seen_q <= 1'b0;
            state_q       <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            src_ack_q     <= 1'b1;
            relock_seen_q <= 1'b0;
            state_q       <= (relock_seen_q || relock) ? LOCKED : UNLOCKED;
          end else if (relock) relock_seen_q <= 1'b1;
        end
`ifdef SDR_LOCKOUT_EN
        LOCKOUT: begin
          if (lock_cnt_q == LOCK_LAST) begin
            fail_cnt_q <= '0;
            state_q    <= LOCKED;
          end else lock_cnt_q <= lock_cnt_q + 16'd1;
        end
`endif
        default: state_q <= NOKEY;
      endcase
    end
  end

  assign src_ack   = src_ack_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign auth_ok   = auth_ok_q;
  assign auth_fail = auth_fail_q;
  assign unlocked  = (state_q == UNLOCKED) || (state_q == SEND);
`ifdef SDR_LOCKOUT_EN
  assign locked_out = (state_q == LOCKOUT);
`else
  assign locked_out = 1'b0;
`endif

endmodule
